// File: rtl/calc_sequencer_if.sv
// calc_sequencer_if: keypad, ALU, register-file and display signals of calc_sequencer.
//
// Handshakes:
//   key   : a key transfers on a rising clock edge where key_valid and key_ready are
//           both high; key_valid/key_code hold stable until that edge.
//   alu   : alu_start is a one-cycle request; alu_a/alu_b/alu_sub stay stable until the
//           one-cycle alu_ready strobe, which qualifies alu_result and alu_overflow.
//   regs  : reg_we is a one-cycle write strobe; reg_rdata returns the word at reg_addr
//           one clock after the address is sampled.
//
// master = the sequencer, slave = the keypad/ALU/register-file environment.
interface calc_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             key_valid;
    logic [3:0]       key_code;
    logic             key_ready;
    logic             alu_start;
    logic             alu_sub;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             alu_ready;
    logic [WIDTH-1:0] alu_result;
    logic             alu_overflow;
    logic [3:0]       reg_addr;
    logic             reg_we;
    logic [WIDTH-1:0] reg_wdata;
    logic [WIDTH-1:0] reg_rdata;
    logic [WIDTH-1:0] x_out;
    logic [WIDTH-1:0] y_out;
    logic             error;
    logic [1:0]       state_dbg;

    modport master (
        input  key_valid, key_code, alu_ready, alu_result, alu_overflow, reg_rdata,
        output key_ready, alu_start, alu_sub, alu_a, alu_b, reg_addr, reg_we,
               reg_wdata, x_out, y_out, error, state_dbg
    );

    modport slave (
        output key_valid, key_code, alu_ready, alu_result, alu_overflow, reg_rdata,
        input  key_ready, alu_start, alu_sub, alu_a, alu_b, reg_addr, reg_we,
               reg_wdata, x_out, y_out, error, state_dbg
    );
endinterface

// File: rtl/calc_sequencer.sv
// calc_sequencer: RPN keypad controller with a two-entry operand stack (X top, Y second).
// Sequences the add/subtract ALU and register-file store/load; all outputs registered.
// Optional macro CALC_SEQ_TIMEOUT_EN: abort an ALU operation to ERROR after ALU_TIMEOUT
// cycles without alu_ready (alu_ready on the timeout cycle still wins).
// WIDTH must be at least 4 (register addresses are taken from X[3:0]).
module calc_sequencer #(
    parameter int WIDTH       = 8,
    parameter int NREGS       = 10,
    parameter int ALU_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    calc_sequencer_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ALU_WAIT = 2'd1,
        REG_READ = 2'd2,
        ERROR    = 2'd3
    } state_t;

    localparam logic [WIDTH+3:0] TEN     = (WIDTH + 4)'(10);
    localparam logic [WIDTH-1:0] NREGS_W = WIDTH'(NREGS);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]       addr_q, addr_d;
    logic             fresh_q, fresh_d;
    logic             start_q, start_d;
    logic             sub_q, sub_d;
    logic             we_q, we_d;
    logic             ready_q, ready_d;
    logic             err_q, err_d;

    logic             key_fire;
    logic [WIDTH+3:0] x_acc;
    logic             x_bad_addr;
    logic             alu_timeout;

    assign key_fire   = bus.key_valid & ready_q;
    // Digit entry needs four spare bits: (2^WIDTH-1)*10+9 < 2^(WIDTH+4).
    assign x_acc      = ({4'b0000, x_q} * TEN) + {{WIDTH{1'b0}}, bus.key_code};
    assign x_bad_addr = (x_q >= NREGS_W);

`ifdef CALC_SEQ_TIMEOUT_EN
    localparam int            TW       = $clog2(ALU_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(ALU_TIMEOUT - 1);

    logic [TW-1:0] tmo_q, tmo_d;

    // Cycle counter: zero on entry to ALU_WAIT, counts every cycle spent waiting.
    always_comb begin
        tmo_d = '0;
        if (state_q == ALU_WAIT) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end

    assign alu_timeout = (tmo_q == TMO_LAST);
`else
    assign alu_timeout = 1'b0;
`endif

    // Next-state and next-output logic for the whole sequencer.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        fresh_d = fresh_q;
        alu_a_d = alu_a_q;
        alu_b_d = alu_b_q;
        sub_d   = sub_q;
        wdata_d = wdata_q;
        start_d = 1'b0;
        we_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (key_fire) begin
                    case (bus.key_code)
                        4'hA, 4'hB: begin
                            alu_a_d = y_q;
                            alu_b_d = x_q;
                            sub_d   = (bus.key_code == 4'hB);
                            start_d = 1'b1;
                            state_d = ALU_WAIT;
                        end
                        4'hC: begin
                            if (x_bad_addr) begin
                                state_d = ERROR;
                            end else begin
                                we_d    = 1'b1;
                                wdata_d = y_q;
                                fresh_d = 1'b1;
                            end
                        end
                        4'hD: begin
                            if (x_bad_addr) begin
                                state_d = ERROR;
                            end else begin
                                state_d = REG_READ;
                            end
                        end
                        4'hE: begin
                            y_d     = x_q;
                            fresh_d = 1'b1;
                        end
                        4'hF: begin
                            x_d     = '0;
                            y_d     = '0;
                            fresh_d = 1'b1;
                        end
                        default: begin
                            if (fresh_q) begin
                                x_d     = WIDTH'(bus.key_code);
                                fresh_d = 1'b0;
                            end else if (x_acc[WIDTH+3:WIDTH] != 4'd0) begin
                                state_d = ERROR;
                            end else begin
                                x_d = x_acc[WIDTH-1:0];
                            end
                        end
                    endcase
                end
            end
            ALU_WAIT: begin
                if (bus.alu_ready) begin
                    if (bus.alu_overflow) begin
                        state_d = ERROR;
                    end else begin
                        x_d     = bus.alu_result;
                        y_d     = '0;
                        fresh_d = 1'b1;
                        state_d = IDLE;
                    end
                end else if (alu_timeout) begin
                    state_d = ERROR;
                end
            end
            REG_READ: begin
                x_d     = bus.reg_rdata;
                fresh_d = 1'b1;
                state_d = IDLE;
            end
            ERROR: begin
                if (key_fire && bus.key_code == 4'hF) begin
                    x_d     = '0;
                    y_d     = '0;
                    fresh_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        err_d   = (state_d == ERROR);
        ready_d = (state_d == IDLE) || (state_d == ERROR);
        // reg_addr shadows X so the register file has already sampled the load address
        // by the time REG_READ begins; this keeps REG_READ to a single cycle despite the
        // one-cycle read latency, and gives store the address X[3:0] as well.
        addr_d  = x_d[3:0];
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            fresh_q <= 1'b1;
            alu_a_q <= '0;
            alu_b_q <= '0;
            sub_q   <= 1'b0;
            wdata_q <= '0;
            addr_q  <= '0;
            start_q <= 1'b0;
            we_q    <= 1'b0;
            ready_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            fresh_q <= fresh_d;
            alu_a_q <= alu_a_d;
            alu_b_q <= alu_b_d;
            sub_q   <= sub_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            start_q <= start_d;
            we_q    <= we_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    assign bus.key_ready = ready_q;
    assign bus.alu_start = start_q;
    assign bus.alu_sub   = sub_q;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.reg_addr  = addr_q;
    assign bus.reg_we    = we_q;
    assign bus.reg_wdata = wdata_q;
    assign bus.x_out     = x_q;
    assign bus.y_out     = y_q;
    assign bus.error     = err_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: keypad traffic against a behavioural RPN calculator model.
`timescale 1ns/1ps
module tb_calc_sequencer;

    localparam int WIDTH       = 8;
    localparam int NREGS       = 10;
    localparam int ALU_TIMEOUT = 15;
    localparam int MAXV        = (1 << WIDTH) - 1;
    localparam int BUSY_ANY    = 63;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    calc_sequencer_if #(.WIDTH(WIDTH)) bus ();

    calc_sequencer #(
        .WIDTH(WIDTH),
        .NREGS(NREGS),
        .ALU_TIMEOUT(ALU_TIMEOUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;

    logic [2*WIDTH:0]   alu_q[$];   // {sub, a, b}
    logic [WIDTH+3:0]   wr_q[$];    // {addr, data}
    logic [2*WIDTH+6:0] st_q[$];    // {busy cycles, error, x, y}
    int                 lat_q[$];   // ALU latency per request, 0 = never answer

    // Reference calculator
    int m_x     = 0;
    int m_y     = 0;
    bit m_fresh = 1'b1;
    bit m_err   = 1'b0;
    int m_mem[16] = '{default: 0};

    int force_lat = 0;
    bit mute_next = 1'b0;

    logic [WIDTH-1:0] rf[16] = '{default: '0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Apply one key to the reference calculator and queue what the DUT must show.
    task automatic model_key(input logic [3:0] k);
        int busy;
        int r;
        int lat;
        bit sub;
        busy = 0;
        if (m_err) begin
            if (k == 4'hF) begin
                m_err = 0; m_x = 0; m_y = 0; m_fresh = 1;
            end
        end else begin
            case (k)
                4'hA, 4'hB: begin
                    sub = (k == 4'hB);
                    alu_q.push_back({sub, WIDTH'(m_y), WIDTH'(m_x)});
                    if (mute_next) begin
                        lat_q.push_back(0);
                        busy  = ALU_TIMEOUT;
                        m_err = 1;
                    end else begin
                        lat = (force_lat != 0) ? force_lat : int'($urandom_range(1, 5));
                        lat_q.push_back(lat);
                        busy = lat + 1;
                        r = sub ? m_y - m_x : m_y + m_x;
                        if (r < 0 || r > MAXV) begin
                            m_err = 1;
                        end else begin
                            m_x = r; m_y = 0; m_fresh = 1;
                        end
                    end
                end
                4'hC: begin
                    if (m_x >= NREGS) begin
                        m_err = 1;
                    end else begin
                        wr_q.push_back({4'(m_x), WIDTH'(m_y)});
                        m_mem[m_x] = m_y;
                        m_fresh = 1;
                    end
                end
                4'hD: begin
                    if (m_x >= NREGS) begin
                        m_err = 1;
                    end else begin
                        m_x = m_mem[m_x];
                        m_fresh = 1;
                        busy = 1;
                    end
                end
                4'hE: begin
                    m_y = m_x; m_fresh = 1;
                end
                4'hF: begin
                    m_x = 0; m_y = 0; m_fresh = 1;
                end
                default: begin
                    if (m_fresh) begin
                        m_x = int'(k); m_fresh = 0;
                    end else if (m_x * 10 + int'(k) > MAXV) begin
                        m_err = 1;
                    end else begin
                        m_x = m_x * 10 + int'(k);
                    end
                end
            endcase
        end
        st_q.push_back({6'(busy), m_err, WIDTH'(m_x), WIDTH'(m_y)});
    endtask

    // ---------------- driver ----------------
    task automatic send_key(input logic [3:0] k);
        int guard;
        model_key(k);
        repeat ($urandom_range(0, 1)) @(negedge clk);
        @(negedge clk);
        bus.key_valid = 1'b1;
        bus.key_code  = k;
        guard = 0;
        do begin
            @(posedge clk);
            guard++;
        end while (!bus.key_ready && guard < 100);
        if (!bus.key_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL key_handshake: key %0h not accepted after %0d cycles", k, guard);
        end
        #1;
        bus.key_valid = 1'b0;
    endtask

    // ---------------- register file model (write-first, 1-cycle read) ----------------
    always @(posedge clk) begin
        if (bus.reg_we) rf[bus.reg_addr] <= bus.reg_wdata;
        bus.reg_rdata <= bus.reg_we ? bus.reg_wdata : rf[bus.reg_addr];
    end

    // ---------------- ALU responder ----------------
    initial begin : alu_model
        int a, b, r, lat;
        bit s;
        bus.alu_ready    = 1'b0;
        bus.alu_result   = '0;
        bus.alu_overflow = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.alu_start) begin
                a   = int'(bus.alu_a);
                b   = int'(bus.alu_b);
                s   = bus.alu_sub;
                lat = (lat_q.size() > 0) ? lat_q.pop_front() : 2;
                if (lat > 0) begin
                    r = s ? a - b : a + b;
                    repeat (lat) @(negedge clk);
                    bus.alu_ready    = 1'b1;
                    bus.alu_result   = WIDTH'(r);
                    bus.alu_overflow = (r < 0) || (r > MAXV);
                    @(negedge clk);
                    bus.alu_ready    = 1'b0;
                    bus.alu_overflow = 1'b0;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin : monitor
        bit fired, pending;
        int busy;
        logic [2*WIDTH:0]   ea;
        logic [WIDTH+3:0]   ew;
        logic [2*WIDTH+6:0] es;
        pending = 0;
        busy    = 0;
        forever begin
            @(posedge clk);
            fired = bus.key_valid && bus.key_ready && !reset;
            @(negedge clk);
            if (reset) begin
                pending = 0;
                alu_q.delete();
                wr_q.delete();
                st_q.delete();
            end else begin
                if (fired) begin
                    pending = 1;
                    busy    = 0;
                end
                if (bus.alu_start) begin
                    n_checks++;
                    if (alu_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL alu_start: unexpected pulse a=%0d b=%0d", bus.alu_a, bus.alu_b);
                    end else begin
                        ea = alu_q.pop_front();
                        check("alu_sub", bus.alu_sub, ea[2*WIDTH]);
                        check("alu_a", bus.alu_a, ea[2*WIDTH-1:WIDTH]);
                        check("alu_b", bus.alu_b, ea[WIDTH-1:0]);
                    end
                end
                if (bus.reg_we) begin
                    n_checks++;
                    if (wr_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL reg_we: unexpected write addr=%0d data=%0d", bus.reg_addr, bus.reg_wdata);
                    end else begin
                        ew = wr_q.pop_front();
                        check("reg_addr", bus.reg_addr, ew[WIDTH+3:WIDTH]);
                        check("reg_wdata", bus.reg_wdata, ew[WIDTH-1:0]);
                    end
                end
                if (pending) begin
                    if (bus.key_ready) begin
                        pending = 0;
                        n_checks++;
                        if (st_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL state: no expectation queued, x=%0d", bus.x_out);
                        end else begin
                            es = st_q.pop_front();
                            check("x_out", bus.x_out, es[2*WIDTH-1:WIDTH]);
                            check("y_out", bus.y_out, es[WIDTH-1:0]);
                            check("error", bus.error, es[2*WIDTH]);
                            if (es[2*WIDTH+6:2*WIDTH+1] != 6'(BUSY_ANY)) begin
                                check("busy_cycles", busy, es[2*WIDTH+6:2*WIDTH+1]);
                            end
                        end
                    end else begin
                        busy++;
                        if (busy > 100) begin
                            pending = 0;
                            n_checks++;
                            n_fail++;
                            $display("FAIL key_ready: still low after %0d cycles", busy);
                        end
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : driver
        bus.key_valid = 1'b0;
        bus.key_code  = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst key_ready", bus.key_ready, 1);
        check("rst x_out", bus.x_out, 0);
        check("rst y_out", bus.y_out, 0);
        check("rst error", bus.error, 0);
        check("rst alu_start", bus.alu_start, 0);
        check("rst alu_sub", bus.alu_sub, 0);
        check("rst alu_a", bus.alu_a, 0);
        check("rst alu_b", bus.alu_b, 0);
        check("rst reg_we", bus.reg_we, 0);
        check("rst reg_addr", bus.reg_addr, 0);
        check("rst reg_wdata", bus.reg_wdata, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Add with a 3-cycle ALU: 12 + 3
        force_lat = 3;
        send_key(4'h1); send_key(4'h2); send_key(4'hE); send_key(4'h3); send_key(4'hA);
        force_lat = 0;

        // Digit overflow, ignored key while in error, clear
        send_key(4'h2); send_key(4'h5); send_key(4'h6); send_key(4'h7); send_key(4'hF);

        // Store 7 into register 4, then load it back
        send_key(4'h7); send_key(4'hE); send_key(4'h4); send_key(4'hC);
        send_key(4'h4); send_key(4'hD);

        // Subtract underflow leaves the stack intact
        send_key(4'hF); send_key(4'h3); send_key(4'hE); send_key(4'h5); send_key(4'hB);
        send_key(4'hF);

        // Out-of-range register addresses
        send_key(4'h1); send_key(4'h2); send_key(4'hC); send_key(4'hF);
        send_key(4'h1); send_key(4'h2); send_key(4'hD); send_key(4'hF);

        // Boundary: largest value, and the last valid register address
        send_key(4'h2); send_key(4'h5); send_key(4'h5); send_key(4'hE);
        send_key(4'h9); send_key(4'hC); send_key(4'h9); send_key(4'hD);
        send_key(4'hF);

        // Reset while waiting on the ALU; its late answer must be ignored
        send_key(4'h3); send_key(4'hE); send_key(4'h4);
        force_lat = 6;
        send_key(4'hA);
        force_lat = 0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        m_x = 0; m_y = 0; m_fresh = 1; m_err = 0;
        @(negedge clk);
        check("post-rst key_ready", bus.key_ready, 1);
        check("post-rst x_out", bus.x_out, 0);
        check("post-rst y_out", bus.y_out, 0);
        check("post-rst error", bus.error, 0);
        repeat (10) @(negedge clk);
        send_key(4'hE);

        // Random traffic
        for (int i = 0; i < 250; i++) begin
            logic [3:0] k;
            if (m_err && $urandom_range(0, 1) == 1) k = 4'hF;
            else k = 4'($urandom_range(0, 15));
            send_key(k);
        end

`ifdef CALC_SEQ_TIMEOUT_EN
        // ALU that never answers
        send_key(4'hF); send_key(4'h1); send_key(4'hE); send_key(4'h2);
        mute_next = 1'b1;
        send_key(4'hA);
        mute_next = 1'b0;
        send_key(4'hF);
`endif

        repeat (20) @(negedge clk);
        check("alu_q drained", alu_q.size(), 0);
        check("wr_q drained", wr_q.size(), 0);
        check("st_q drained", st_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
